instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the instruction buffer entries and the maximum number of credits.
REQ-003 SHALL have port clk_sys_i  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_sys_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_req_o  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr_o  output  32  fetch address; word-aligned.
REQ-007 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid_i  input  1  read data valid; in order, at least 1 cycle after the matching grant.
REQ-009 SHALL have port imem_rdata_i  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_i  input  1  control-flow redirect (branch/jump) from a later stage.
REQ-011 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-012 SHALL have port instr_valid_o  output  1  buffer head holds a valid instruction for the decode stage.
REQ-013 SHALL have port instr_o  output  32  instruction at the buffer head.
REQ-014 SHALL have port pc_o  output  32  PC of instr_o.
REQ-015 SHALL have port id_ready_i  input  1  decode stage accepts instr_o this cycle.

Function
REQ-016 SHALL hold the fetch PC in a register; imem_addr_o SHALL equal that register, with bits [1:0] always 0.
REQ-017 SHALL assert imem_req_o when the count of outstanding requests plus the count of buffered entries is less than BUF_DEPTH, and no redirect is asserted in that cycle.
REQ-018 While imem_req_o=1 and imem_gnt_i=0, imem_addr_o SHALL stay stable; only a redirect may change it.
REQ-019 On the cycle imem_req_o=1 and imem_gnt_i=1: PC SHALL become PC+4 (32-bit wrap, 32'hFFFF_FFFC to 0); the issued address SHALL be pushed to an in-order pending-PC queue; the outstanding count SHALL increment.
REQ-020 On imem_rvalid_i=1, the head of the pending-PC queue SHALL pop and the outstanding count SHALL decrement.
REQ-021 On imem_rvalid_i=1, imem_rdata_i and its PC SHALL be pushed into the instruction buffer, unless that response is marked discard.
REQ-022 The instruction buffer SHALL be a FIFO of BUF_DEPTH entries.
REQ-023 instr_valid_o SHALL be 1 iff the buffer is non-empty.
REQ-024 On instr_valid_o and id_ready_i both 1, the buffer head SHALL pop.
REQ-025 Push and pop in the same cycle SHALL both occur, with count unchanged.
REQ-026 The credit rule (REQ-017) SHALL guarantee no push into a full buffer; a push into a full buffer is an assertion error.
REQ-027 Minimum latency SHALL be grant at cycle N, rvalid at N+1, then instr_valid_o=1 at N+2, because the buffer is registered.
REQ-028 On redirect_i=1:
- the buffer SHALL be emptied;
- PC SHALL load {redirect_pc_i[31:2],2'b00} next cycle;
- every request outstanding after this cycle's grant/rvalid updates, including one granted in the same cycle, SHALL be marked discard via a discard counter;
- subsequent responses SHALL decrement that counter and not be buffered.
REQ-029 Redirect SHALL take priority over simultaneous pop, push, and grant-driven PC increment.
REQ-030 Credits SHALL treat discard-marked outstanding requests as occupying slots until their responses return.
REQ-031 Redirect during a pending ungranted request SHALL abandon it: imem_req_o=0 in the redirect cycle, and the new address is requested from the next cycle.
REQ-032 A redirect on consecutive cycles SHALL take the last target and accumulate discards correctly.

Reset
REQ-033 With rst_sys_i=1 at a clock edge, the block SHALL set:
- PC=RESET_PC;
- buffer, pending queue, outstanding count and discard count empty/0;
- instr_valid_o=0, imem_req_o=0, instr_o=0, pc_o=0.
REQ-034 rst_sys_i SHALL override redirect_i and all handshakes; a reset mid-transaction SHALL drop all in-flight state, and responses arriving after reset SHALL be ignored until new grants are made.
REQ-035 The first imem_req_o=1 SHALL appear in the first cycle after rst_sys_i falls.

Verification
REQ-036 Streaming: gnt always 1, rvalid 1 cycle later, id_ready=1, RESET_PC=0 -> instr_o/pc_o sequence 0x0,0x4,0x8... with one instruction per cycle after 2-cycle fill.
REQ-037 Backpressure: id_ready=0 for 5 cycles -> at most 2 buffered; imem_req_o=0 once credits are exhausted; no loss or duplication after id_ready=1 is restored.
REQ-038 Redirect with 2 outstanding: redirect_pc_i=32'h0000_1003 -> next imem_addr_o=32'h0000_1000; the 2 stale responses are dropped; first delivered pc_o=32'h0000_1000.
REQ-039 Simultaneous redirect, grant, rvalid and pop in one cycle -> buffer empty; granted response discarded; no instruction from the old path reaches instr_o.
REQ-040 Random gnt/rvalid delays (0-4 cycles) plus random redirects and a reset mid-run -> scoreboard: pc_o strictly sequential between redirects, each instr_o matches the memory model, and all outputs are 0 the cycle after reset.
REQ-041 Wrap: PC=32'hFFFF_FFF8 -> fetched addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: keeps the fetch PC and issues word requests to
// instruction memory. It accepts in-order responses into a small instruction
// buffer that feeds decode. A redirect flushes the buffer and marks in-flight
// responses for discard.
//
// Ports:
//   clk_sys_i, rst_sys_i          system clock, synchronous active-high reset
//   imem_req_o / imem_addr_o      fetch request and word-aligned address
//   imem_gnt_i                    request accepted this cycle
//   imem_rvalid_i / imem_rdata_i  in-order read response
//   redirect_i / redirect_pc_i    control-flow redirect and its target
//   instr_valid_o/instr_o/pc_o    buffer head presented to decode
//   id_ready_i                    decode consumes the buffer head
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_disc_cnt;
  logic [CNT_W-1:0] r_buf_cnt;

  // Pending-PC queue: address of every granted, not yet answered request.
  logic [31:0]      r_pq [BUF_DEPTH];
  logic [PTR_W-1:0] r_pq_rd;
  logic [PTR_W-1:0] r_pq_wr;

  // Instruction buffer.
  logic [31:0]      r_ib_instr [BUF_DEPTH];
  logic [31:0]      r_ib_pc    [BUF_DEPTH];
  logic [PTR_W-1:0] r_ib_rd;
  logic [PTR_W-1:0] r_ib_wr;

  logic             w_rvalid;
  logic             w_discard;
  logic             w_pop;
  logic             w_push;
  logic [SUM_W-1:0] w_slots;
  logic             w_req;
  logic             w_grant;
  logic [CNT_W-1:0] w_out_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign w_rvalid  = imem_rvalid_i && (r_out_cnt != '0);
  assign w_discard = (r_disc_cnt != '0);
  assign w_pop     = (r_buf_cnt != '0) && id_ready_i && !redirect_i;
  assign w_push    = w_rvalid && !w_discard && !redirect_i;

  // Slots in use: outstanding (incl. discard-marked) plus buffered entries that
  // remain after this cycle's pop, so a full-rate stream keeps one fetch per cycle.
  assign w_slots   = SUM_W'(r_out_cnt) + SUM_W'(r_buf_cnt) - SUM_W'(w_pop);
  assign w_req     = !rst_sys_i && !redirect_i && (w_slots < SUM_W'(BUF_DEPTH));
  assign w_grant   = w_req && imem_gnt_i;
  assign w_out_nxt = r_out_cnt + CNT_W'(w_grant) - CNT_W'(w_rvalid);

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = (r_buf_cnt != '0);
  assign instr_o       = instr_valid_o ? r_ib_instr[r_ib_rd] : '0;
  assign pc_o          = instr_valid_o ? r_ib_pc[r_ib_rd]    : '0;

  // State update; redirect wins over grant, push and pop.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_pc       <= {RESET_PC[31:2], 2'b00};
      r_out_cnt  <= '0;
      r_disc_cnt <= '0;
      r_buf_cnt  <= '0;
      r_pq       <= '{default: '0};
      r_pq_rd    <= '0;
      r_pq_wr    <= '0;
      r_ib_instr <= '{default: '0};
      r_ib_pc    <= '{default: '0};
      r_ib_rd    <= '0;
      r_ib_wr    <= '0;
    end else begin
      if (redirect_i) begin
        r_pc <= {redirect_pc_i[31:2], 2'b00};
      end else if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_grant) begin
        r_pq[r_pq_wr] <= r_pc;
        r_pq_wr       <= ptr_inc(r_pq_wr);
      end
      if (w_rvalid) begin
        r_pq_rd <= ptr_inc(r_pq_rd);
      end
      r_out_cnt <= w_out_nxt;

      // Everything still in flight after a redirect belongs to the old path.
      if (redirect_i) begin
        r_disc_cnt <= w_out_nxt;
      end else if (w_rvalid && w_discard) begin
        r_disc_cnt <= r_disc_cnt - CNT_W'(1);
      end

      if (redirect_i) begin
        r_buf_cnt <= '0;
        r_ib_rd   <= '0;
        r_ib_wr   <= '0;
      end else begin
        if (w_push) begin
          r_ib_instr[r_ib_wr] <= imem_rdata_i;
          r_ib_pc[r_ib_wr]    <= r_pq[r_pq_rd];
          r_ib_wr             <= ptr_inc(r_ib_wr);
        end
        if (w_pop) begin
          r_ib_rd <= ptr_inc(r_ib_rd);
        end
        r_buf_cnt <= r_buf_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // The slot accounting must never let a response land in a full buffer.
  a_no_full_push: assert property (@(posedge clk_sys_i) disable iff (rst_sys_i)
    !(w_push && (r_buf_cnt == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: memory responder with random grant/latency,
// a slot/PC reference model, and a scoreboard of expected deliveries.
module tb_instr_fetch;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_sys_i = 1'b0;
  logic        rst_sys_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        id_ready_i;

  instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_i    (rst_sys_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .id_ready_i   (id_ready_i)
  );

  initial forever #5 clk_sys_i = ~clk_sys_i;

  typedef struct { logic [31:0] data; int rdy; int ep; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_t        mem_q[$];   // granted requests awaiting their response
  exp_t        sb[$];      // instructions decode should still receive, in order
  logic [31:0] glog[$];    // granted addresses, logged on demand

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          epoch = 0;
  int          buf_m = 0;  // instructions returned on the live path, not yet consumed
  logic [31:0] model_pc;
  bit          prev_rst = 1'b1;
  int          k_gnt = 100, k_dmin = 0, k_dmax = 0, k_rdy = 100, k_redir = 0;
  bit          k_stray = 1'b0;
  bit          cnt_en = 1'b0;
  bit          log_en = 1'b0;
  int          vcount = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every instruction decode takes must be the next expected one.
  always @(negedge clk_sys_i) begin
    if (rst_sys_i || redirect_i) begin
      sb.delete();
    end else if (instr_valid_o && id_ready_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL deliver_unexpected: got pc %h instr %h expected nothing", pc_o, instr_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("deliver_pc", pc_o, e.pc);
        check("deliver_instr", instr_o, e.instr);
      end
    end
  end

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic run_cycle(input bit f_rst, input bit f_redir, input logic [31:0] f_rpc);
    bit   rv, dl, exp_req, grant;
    int   bm, r;
    mem_t hd;
    mem_t ne;
    exp_t ex;
    rst_sys_i     = f_rst;
    redirect_i    = f_redir || (k_redir > 0 && $urandom_range(0, 99) < k_redir);
    redirect_pc_i = f_redir ? f_rpc : $urandom;
    id_ready_i    = ($urandom_range(0, 99) < k_rdy);
    imem_gnt_i    = ($urandom_range(0, 99) < k_gnt);
    rv            = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_q[0].data : $urandom;
    if (k_stray && prev_rst && !f_rst && !rv) begin
      // Leftover response right after reset; nothing is outstanding.
      imem_rvalid_i = 1'b1;
      imem_gnt_i    = 1'b0;
    end
    #1;
    bm      = buf_m;
    dl      = (bm > 0) && id_ready_i && !redirect_i && !f_rst;
    exp_req = !f_rst && !redirect_i && ((mem_q.size() + bm - (dl ? 1 : 0)) < int'(DEPTH));
    grant   = exp_req && imem_gnt_i;
    if (prev_rst) begin
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_instr", instr_o, 32'd0);
      check("rst_pc", pc_o, 32'd0);
    end
    check("req", 32'(imem_req_o), 32'(exp_req));
    check("valid", 32'(instr_valid_o), 32'(bm > 0));
    if (exp_req) check("addr", imem_addr_o, model_pc);
    if (cnt_en && instr_valid_o) vcount++;
    if (log_en && grant) glog.push_back(imem_addr_o);
    if (rv) hd = mem_q.pop_front();
    if (f_rst) begin
      mem_q.delete();
      buf_m    = 0;
      epoch++;
      model_pc = {RST_PC[31:2], 2'b00};
    end else if (redirect_i) begin
      buf_m    = 0;
      epoch++;
      model_pc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (rv && hd.ep == epoch) buf_m++;
      if (dl) buf_m--;
      if (grant) begin
        r = cyc + 1 + $urandom_range(k_dmin, k_dmax);
        if (mem_q.size() > 0 && r <= mem_q[$].rdy) r = mem_q[$].rdy + 1;
        ne.data = memf(imem_addr_o);
        ne.rdy  = r;
        ne.ep   = epoch;
        mem_q.push_back(ne);
        ex.pc    = model_pc;
        ex.instr = memf(model_pc);
        sb.push_back(ex);
        model_pc = model_pc + 32'd4;
      end
    end
    prev_rst = f_rst;
    cyc++;
    @(posedge clk_sys_i);
    #1;
  endtask

  initial begin
    int w;
    rst_sys_i     = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    id_ready_i    = 1'b0;
    model_pc      = {RST_PC[31:2], 2'b00};
    @(posedge clk_sys_i);
    #1;
    run_cycle(1, 0, 0);
    run_cycle(1, 0, 0);

    // Streaming: one instruction per cycle after a two-cycle fill.
    cnt_en = 1'b1;
    repeat (30) run_cycle(0, 0, 0);
    cnt_en = 1'b0;
    check("stream_rate", 32'(vcount), 32'd28);

    // Backpressure: decode stalls, slots run out, then stream resumes.
    k_rdy = 0;
    repeat (8) run_cycle(0, 0, 0);
    k_rdy = 100;
    repeat (10) run_cycle(0, 0, 0);

    // Redirect with two requests in flight.
    k_dmin = 3;
    k_dmax = 3;
    w = 0;
    while (mem_q.size() != 2 && w < 20) begin
      run_cycle(0, 0, 0);
      w++;
    end
    if (w == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL two_outstanding_wait: got %0d in flight expected 2", mem_q.size());
    end
    run_cycle(0, 1, 32'h0000_1003);
    check("redir_addr", imem_addr_o, 32'h0000_1000);
    repeat (15) run_cycle(0, 0, 0);

    // Redirect in a cycle that also has grant, response and pop.
    k_dmin = 0;
    k_dmax = 0;
    repeat (10) run_cycle(0, 0, 0);
    run_cycle(0, 1, 32'h0000_2000);
    check("flush_valid", 32'(instr_valid_o), 32'd0);
    check("flush_addr", imem_addr_o, 32'h0000_2000);
    repeat (10) run_cycle(0, 0, 0);

    // Address wrap at the top of the space.
    run_cycle(0, 1, 32'hFFFF_FFF8);
    log_en = 1'b1;
    repeat (8) run_cycle(0, 0, 0);
    log_en = 1'b0;
    if (glog.size() >= 3) begin
      check("wrap0", glog[0], 32'hFFFF_FFF8);
      check("wrap1", glog[1], 32'hFFFF_FFFC);
      check("wrap2", glog[2], 32'h0000_0000);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_grants: got %0d grants expected at least 3", glog.size());
    end

    // Random traffic with redirects and a reset in the middle.
    k_gnt   = 60;
    k_dmin  = 0;
    k_dmax  = 4;
    k_rdy   = 70;
    k_redir = 3;
    k_stray = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 1501) run_cycle(1, 0, 0);
      else run_cycle(0, 0, 0);
    end

    // Drain: no new grants, everything expected must come out.
    k_gnt   = 0;
    k_rdy   = 100;
    k_redir = 0;
    k_stray = 1'b0;
    w = 0;
    while ((mem_q.size() != 0 || buf_m != 0) && w < 200) begin
      run_cycle(0, 0, 0);
      w++;
    end
    run_cycle(0, 0, 0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
